muxn_rr_reg: RTL and testbench
==============================

// Module: muxn_rr_reg
// PURPOSE
//  Parametrised N:1 data mux with built-in round-robin arbitration and a registered valid/ready output.
//  Successor to the fixed 4:1 combinational mux: any input count, per-input valid/grant handshake,
//  optional forced select. Sits where several hart/unit sources share one downstream port
//  (e.g. shared memory or CSR path).
// PARAMETERS
//  MUX_DATA_WIDTH  32  width of each data input and of o_data
//  NUM_INPUTS      4   number of channels, >=2
//  SEL_W  $clog2(NUM_INPUTS)  localparam: width of select/index fields
// PORTS
//  i_clk      in   1                      clock, all state on rising edge
//  i_rstn     in   1                      asynchronous active-low reset
//  i_in       in   NUM_INPUTS*MUX_DATA_WIDTH  channel k data at [k*W +: W]
//  i_valid    in   NUM_INPUTS             per-channel request
//  i_last     in   NUM_INPUTS             per-channel end-of-packet (used only with MUXN_PKT_LOCK_EN)
//  o_gnt      out  NUM_INPUTS             one-hot accept this cycle (combinational)
//  i_force_en in   1                      1: select channel i_sel instead of round-robin
//  i_sel      in   SEL_W                  forced channel index
//  o_valid    out  1                      output register holds data
//  o_data     out  MUX_DATA_WIDTH         registered selected data
//  o_src      out  SEL_W                  index of channel that produced o_data
//  i_ready    in   1                      downstream accepts o_data when o_valid&i_ready
// BEHAVIOUR
//  - Reset (i_rstn=0, async): o_valid=0, o_data=0, o_src=0, rr pointer=0, lock cleared. o_gnt=0 while in reset.
//  - load = !o_valid | i_ready. No accept when load=0; o_gnt=0; o_* hold.
//  - RR mode (i_force_en=0): winner = first k with i_valid[k], scanning ptr, ptr+1, ... wrapping mod NUM_INPUTS.
//  - Forced mode: winner = i_sel iff i_valid[i_sel]; i_sel>=NUM_INPUTS or invalid -> no winner. ptr unchanged.
//  - Accept: load & winner exists -> o_gnt[winner]=1; next edge o_data=i_in[winner], o_src=winner, o_valid=1.
//    In RR mode ptr <= (winner+1) mod NUM_INPUTS (wraps from N-1 to 0).
//  - load & no winner -> o_valid<=0 next edge (o_data/o_src hold).
//  - Latency 1 cycle input->output; full throughput (one beat/cycle) while i_ready=1.
//  - Simultaneous drain+accept (o_valid&i_ready&winner): old beat leaves, new beat loaded same edge.
//  - Source must hold i_valid/data until its o_gnt bit; o_data stable while o_valid&!i_ready.
//  - Reset mid-transfer: held beat discarded, no o_gnt issued.
// CONFIGURATION
//  MUXN_PKT_LOCK_EN defined: after accepting a beat with i_last[k]=0, grant locks to channel k
//   (RR and i_force_en ignored) until a beat from k with i_last[k]=1 is accepted; ptr then advances to k+1.
//   While locked and !i_valid[k], no accept (bubble), no switch.
//  Not defined: every beat arbitrated independently; i_last ignored; no lock state synthesised.
// STRUCTURE
//  Package muxn_pkg: function sel_w(n) = max(1,$clog2(n)); typedef of arb mode enum {ARB_RR, ARB_FORCE, ARB_LOCK}.
//  Sub-module rr_pick: combinational rotate-priority encoder (req, ptr -> found, idx); instantiated once.
//  Top: load/lock logic, output register, pointer register.
// TESTING  (bench uses NUM_INPUTS=4, MUX_DATA_WIDTH=32, in[k]=32'hA000_000k)
//  1 Reset: hold i_rstn=0 with i_valid=4'hF -> o_valid=0, o_data=0, o_gnt=0; release -> first grant ch0.
//  2 RR fairness: i_valid=4'hF, i_ready=1 for 8 cycles -> o_src 0,1,2,3,0,1,2,3, one beat per cycle.
//  3 Wrap/skip: ptr=3, i_valid=4'b0101 -> grant ch0 (not ch2); next grant ch2.
//  4 Backpressure: o_valid=1, i_ready=0 3 cycles -> o_gnt=0, o_data held; i_ready=1 -> drain+reload same edge.
//  5 Force: i_force_en=1, i_sel=2, i_valid=4'hF -> only ch2 granted, ptr unchanged;
//    i_sel=2, i_valid[2]=0 -> o_valid drops.
//  6 Lock (MUXN_PKT_LOCK_EN): ch1 3-beat packet i_last=0,0,1 with ch0/ch2 valid -> o_src=1,1,1 then ch2.

Source files
------------

// File: rtl/muxn_rr_reg_pkg.sv
// Shared types and helpers for the muxn_rr_reg N:1 round-robin mux.
package muxn_rr_reg_pkg;

    typedef enum logic [1:0] {
        ARB_RR,
        ARB_FORCE,
        ARB_LOCK
    } arb_mode_e;

    // Select fields stay at least one bit wide, even for tiny muxes.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_rr_reg_if.sv
// Channel-side bundle of muxn_rr_reg: per-channel data/valid/last/grant,
// forced select, and the registered valid/ready output port.
interface muxn_rr_reg_if
    import muxn_rr_reg_pkg::*;
#(
    parameter int unsigned MUX_DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS     = 4
);
    localparam int unsigned SEL_W = sel_w(NUM_INPUTS);

    logic [NUM_INPUTS*MUX_DATA_WIDTH-1:0] i_in;
    logic [NUM_INPUTS-1:0]                i_valid;
    logic [NUM_INPUTS-1:0]                i_last;
    logic [NUM_INPUTS-1:0]                o_gnt;
    logic                                 i_force_en;
    logic [SEL_W-1:0]                     i_sel;
    logic                                 o_valid;
    logic [MUX_DATA_WIDTH-1:0]            o_data;
    logic [SEL_W-1:0]                     o_src;
    logic                                 i_ready;

    modport master (
        output i_in, i_valid, i_last, i_force_en, i_sel, i_ready,
        input  o_gnt, o_valid, o_data, o_src
    );

    modport slave (
        input  i_in, i_valid, i_last, i_force_en, i_sel, i_ready,
        output o_gnt, o_valid, o_data, o_src
    );

endinterface

// File: rtl/muxn_rr_reg_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [SEL_W-1:0]      ptr_i,
    output logic                  found_o,
    output logic [SEL_W-1:0]      idx_o
);

    int unsigned      k;
    logic [SEL_W-1:0] kidx;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        kidx    = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= NUM_INPUTS) k = k - NUM_INPUTS;
            kidx = k[SEL_W-1:0];
            if (!found_o && req_i[kidx]) begin
                found_o = 1'b1;
                idx_o   = kidx;
            end
        end
    end

endmodule

// File: rtl/muxn_rr_reg.sv
// N:1 round-robin mux with registered valid/ready output and forced select.
// Define MUXN_PKT_LOCK_EN to hold the grant on one channel until its i_last beat.
module muxn_rr_reg
    import muxn_rr_reg_pkg::*;
#(
    parameter int unsigned MUX_DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS     = 4
) (
    input logic          i_clk,
    input logic          i_rstn,
    muxn_rr_reg_if.slave bus
);

    localparam int unsigned SEL_W = sel_w(NUM_INPUTS);
    localparam int unsigned W     = MUX_DATA_WIDTH;

    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic [W-1:0]          data_q, data_d;
    logic [SEL_W-1:0]      src_q, src_d;

    logic                  rr_found;
    logic [SEL_W-1:0]      rr_idx;
    arb_mode_e             mode;
    logic                  sel_ok;
    logic                  load;
    logic                  win_found;
    logic [SEL_W-1:0]      win_idx;
    logic [SEL_W-1:0]      win_next;
    logic                  accept;
    logic [NUM_INPUTS-1:0] gnt;

`ifdef MUXN_PKT_LOCK_EN
    logic                  lock_q, lock_d;
    logic [SEL_W-1:0]      lock_ch_q, lock_ch_d;
`else
    logic                  lock_q;
    logic [SEL_W-1:0]      lock_ch_q;
    logic                  unused_last;

    assign lock_q      = 1'b0;
    assign lock_ch_q   = '0;
    assign unused_last = ^bus.i_last;
`endif

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_rr_pick (
        .req_i   (bus.i_valid),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    // Out-of-range forced indices never win.
    assign sel_ok   = (32'(bus.i_sel) < NUM_INPUTS) && bus.i_valid[bus.i_sel];
    assign win_next = (32'(win_idx) == NUM_INPUTS - 1) ? '0 : win_idx + 1'b1;

    always_comb begin
        mode = ARB_RR;
        if (lock_q) begin
            mode = ARB_LOCK;
        end else if (bus.i_force_en) begin
            mode = ARB_FORCE;
        end
    end

    always_comb begin
        load      = !valid_q || bus.i_ready;
        win_found = 1'b0;
        win_idx   = '0;
        unique case (mode)
            ARB_RR: begin
                win_found = rr_found;
                win_idx   = rr_idx;
            end
            ARB_FORCE: begin
                win_found = sel_ok;
                win_idx   = bus.i_sel;
            end
            ARB_LOCK: begin
                win_found = bus.i_valid[lock_ch_q];
                win_idx   = lock_ch_q;
            end
            default: ;
        endcase

        // No grant may escape while reset is asserted.
        accept = load && win_found && i_rstn;
        gnt    = '0;
        if (accept) gnt[win_idx] = 1'b1;

        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (load) valid_d = win_found;
        if (accept) begin
            data_d = bus.i_in[win_idx*W +: W];
            src_d  = win_idx;
            if (mode == ARB_RR) ptr_d = win_next;
        end

`ifdef MUXN_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            lock_d    = !bus.i_last[win_idx];
            lock_ch_d = win_idx;
            if (lock_q && bus.i_last[win_idx]) ptr_d = win_next;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

`ifdef MUXN_PKT_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`endif

    assign bus.o_gnt   = gnt;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_src   = src_q;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg (4 channels, 32-bit, channel k data = A000_000k).
module tb_muxn_rr_reg;
    import muxn_rr_reg_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    muxn_rr_reg_if #(.MUX_DATA_WIDTH(W), .NUM_INPUTS(N)) bus ();

    muxn_rr_reg #(
        .MUX_DATA_WIDTH (W),
        .NUM_INPUTS     (N)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) bus.i_in[k*W +: W] = 32'hA000_0000 | 32'(k);
        rstn           = 1'b0;
        bus.i_valid    = 4'hF;
        bus.i_last     = 4'h0;
        bus.i_force_en = 1'b0;
        bus.i_sel      = '0;
        bus.i_ready    = 1'b1;

        // Reset holds everything quiet even with all channels requesting
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data", bus.o_data, 32'd0);
        check("rst_gnt", 32'(bus.o_gnt), 32'd0);
        rstn = 1'b1;
        #1;

        // Round-robin fairness, one beat per cycle
        for (int i = 0; i < 8; i++) begin
            check("rr_gnt", 32'(bus.o_gnt), 32'd1 << (i % 4));
            tick();
            check("rr_src", 32'(bus.o_src), 32'(i % 4));
            check("rr_data", bus.o_data, 32'hA000_0000 | 32'(i % 4));
            check("rr_valid", 32'(bus.o_valid), 32'd1);
        end

        // Wrap and skip: park ptr at 3, then 0101 picks ch0 before ch2
        bus.i_valid = 4'b0100;
        #1;
        check("park_gnt", 32'(bus.o_gnt), 32'h4);
        tick();
        check("park_src", 32'(bus.o_src), 32'd2);
        bus.i_valid = 4'b0101;
        #1;
        check("wrap_gnt", 32'(bus.o_gnt), 32'h1);
        tick();
        check("wrap_src", 32'(bus.o_src), 32'd0);
        #1;
        check("skip_gnt", 32'(bus.o_gnt), 32'h4);
        tick();
        check("skip_src", 32'(bus.o_src), 32'd2);
        check("skip_data", bus.o_data, 32'hA000_0002);

        // Backpressure holds the beat; release drains and reloads on one edge
        bus.i_ready = 1'b0;
        bus.i_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_gnt", 32'(bus.o_gnt), 32'd0);
            tick();
            check("bp_data", bus.o_data, 32'hA000_0002);
            check("bp_valid", 32'(bus.o_valid), 32'd1);
        end
        bus.i_ready = 1'b1;
        #1;
        check("rel_gnt", 32'(bus.o_gnt), 32'h8);
        tick();
        check("rel_src", 32'(bus.o_src), 32'd3);
        check("rel_data", bus.o_data, 32'hA000_0003);
        check("rel_valid", 32'(bus.o_valid), 32'd1);

        // Forced select: only ch2, pointer left at 0
        bus.i_force_en = 1'b1;
        bus.i_sel      = 2'd2;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("frc_gnt", 32'(bus.o_gnt), 32'h4);
            tick();
            check("frc_src", 32'(bus.o_src), 32'd2);
        end
        bus.i_force_en = 1'b0;
        #1;
        check("frc_ptr", 32'(bus.o_gnt), 32'h1);
        bus.i_force_en = 1'b1;
        bus.i_valid    = 4'b1011;
        #1;
        check("frc_idle_gnt", 32'(bus.o_gnt), 32'd0);
        tick();
        check("frc_idle_valid", 32'(bus.o_valid), 32'd0);
        check("frc_idle_data", bus.o_data, 32'hA000_0002);

        // Reset mid-transfer discards the held beat
        bus.i_force_en = 1'b0;
        bus.i_valid    = 4'hF;
        tick();
        check("mid_valid", 32'(bus.o_valid), 32'd1);
        bus.i_ready = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_gnt", 32'(bus.o_gnt), 32'd0);
        check("mid_rst_data", bus.o_data, 32'd0);
        tick();
        rstn        = 1'b1;
        bus.i_ready = 1'b1;

`ifdef MUXN_PKT_LOCK_EN
        // Ch1 3-beat packet with a bubble; ch0/ch2 must wait for the last beat
        bus.i_valid = 4'b0010;
        bus.i_last  = 4'b0000;
        #1;
        check("lk_gnt0", 32'(bus.o_gnt), 32'h2);
        tick();
        check("lk_src0", 32'(bus.o_src), 32'd1);
        bus.i_valid = 4'b0101;
        #1;
        check("lk_bubble_gnt", 32'(bus.o_gnt), 32'd0);
        tick();
        check("lk_bubble_valid", 32'(bus.o_valid), 32'd0);
        bus.i_valid = 4'b0111;
        #1;
        check("lk_gnt1", 32'(bus.o_gnt), 32'h2);
        tick();
        check("lk_src1", 32'(bus.o_src), 32'd1);
        bus.i_last = 4'b0010;
        #1;
        check("lk_gnt2", 32'(bus.o_gnt), 32'h2);
        tick();
        check("lk_src2", 32'(bus.o_src), 32'd1);
        bus.i_last = 4'b0000;
        #1;
        check("lk_after_gnt", 32'(bus.o_gnt), 32'h4);
        tick();
        check("lk_after_src", 32'(bus.o_src), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
